// File: rtl/io_poll_master.sv
// io_poll_master
//   Bus initiator that stands in for the CPU memory port on test and bring-up
//   builds. Each poll round reads the two switch registers, then writes sw1,
//   sw2 and their 8-bit sum to the three LCD registers. After the writes it
//   idles for POLL_PERIOD cycles. It then starts another round if enable is
//   high, or returns to IDLE if it is low.
//
//   Optional feature (macro CHANGE_ONLY_WR_EN): when a round reads the same
//   switch values as the last round that wrote, the write cycles still
//   elapse, but we stays low and sum is left alone. round_cnt still counts
//   that round.
//
// Ports
//   clock      in   system clock, all state updates on posedge
//   resetn     in   asynchronous active-low reset
//   enable     in   level; keep running poll rounds while high
//   addr       out  [31:0] bus address (registered)
//   wdata      out  [31:0] bus write data (registered)
//   we         out  bus write enable, one-cycle pulse per write (registered)
//   rdata      in   [31:0] bus read data, only bits [7:0] are used
//   busy       out  high whenever the FSM is not in IDLE
//   sum        out  [7:0] last written sum, (sw1 + sw2) & 8'hFF
//   round_cnt  out  [15:0] completed poll rounds, wraps to 0
module io_poll_master #(
  parameter int unsigned POLL_PERIOD = 50000,
  parameter int unsigned READ_LAT    = 1,
  parameter logic [31:0] SW1_ADDR    = 32'h80,
  parameter logic [31:0] SW2_ADDR    = 32'h84,
  parameter logic [31:0] LCD1_ADDR   = 32'h88,
  parameter logic [31:0] LCD2_ADDR   = 32'h90,
  parameter logic [31:0] LCD3_ADDR   = 32'h98
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        enable,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic        we,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic [7:0]  sum,
  output logic [15:0] round_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_SW1 = 3'd1;
  localparam logic [2:0] RD_SW2 = 3'd2;
  localparam logic [2:0] WR_L1  = 3'd3;
  localparam logic [2:0] WR_L2  = 3'd4;
  localparam logic [2:0] WR_L3  = 3'd5;
  localparam logic [2:0] WAIT   = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;       // cycles spent in the current read / wait state
  logic [7:0]  sw1_q, sw1_d, sw2_q, sw2_d;
  logic [7:0]  sum_q, sum_d;
  logic [15:0] rc_q, rc_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        we_q, we_d, busy_q, busy_d;

  logic        rd_last;            // this edge is the capture edge of a read
  logic        skip_d, skip_q;     // suppress the writes of the current round

  // Only the low byte of read data matters.
  logic        unused_rdata;
  assign unused_rdata = ^rdata[31:8];

  assign rd_last = (cnt_q == READ_LAT - 1);

`ifdef CHANGE_ONLY_WR_EN
  logic [7:0] last_sw1_q, last_sw2_q;
  logic       last_vld_q;

  // The skip decision is made on the sw2 capture edge, using the fresh rdata.
  // It holds for the three write cycles that follow.
  always_comb begin
    skip_d = skip_q;
    if (state_q == RD_SW2 && rd_last)
      skip_d = last_vld_q && (sw1_q == last_sw1_q) && (rdata[7:0] == last_sw2_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      skip_q     <= 1'b0;
      last_sw1_q <= 8'd0;
      last_sw2_q <= 8'd0;
      last_vld_q <= 1'b0;
    end else begin
      skip_q <= skip_d;
      if (state_q == WR_L3 && !skip_q) begin
        last_sw1_q <= sw1_q;
        last_sw2_q <= sw2_q;
        last_vld_q <= 1'b1;
      end
    end
  end
`else
  assign skip_d = 1'b0;
  assign skip_q = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    sw1_d   = sw1_q;
    sw2_d   = sw2_q;
    sum_d   = sum_q;
    rc_d    = rc_q;
    case (state_q)
      IDLE: begin
        cnt_d = 32'd0;
        if (enable) state_d = RD_SW1;
      end
      RD_SW1: if (rd_last) begin
        sw1_d   = rdata[7:0];
        cnt_d   = 32'd0;
        state_d = RD_SW2;
      end
      RD_SW2: if (rd_last) begin
        sw2_d   = rdata[7:0];
        cnt_d   = 32'd0;
        state_d = WR_L1;
      end
      WR_L1: state_d = WR_L2;
      WR_L2: state_d = WR_L3;
      WR_L3: begin
        state_d = WAIT;
        cnt_d   = 32'd0;
        rc_d    = rc_q + 16'd1;
        if (!skip_q) sum_d = sw1_q + sw2_q;
      end
      WAIT: if (cnt_q == POLL_PERIOD - 1) begin
        // enable is sampled only here, so a round is never cut short.
        cnt_d   = 32'd0;
        state_d = enable ? RD_SW1 : IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // The bus outputs are decoded from the next state and then registered.
  // As a result they change only on the clock edge and cannot glitch.
  always_comb begin
    addr_d  = 32'd0;
    wdata_d = 32'd0;
    we_d    = 1'b0;
    case (state_d)
      RD_SW1: addr_d = SW1_ADDR;
      RD_SW2: addr_d = SW2_ADDR;
      WR_L1: begin
        addr_d  = LCD1_ADDR;
        wdata_d = {24'd0, sw1_d};
        we_d    = !skip_d;
      end
      WR_L2: begin
        addr_d  = LCD2_ADDR;
        wdata_d = {24'd0, sw2_q};
        we_d    = !skip_d;
      end
      WR_L3: begin
        addr_d  = LCD3_ADDR;
        wdata_d = {24'd0, sw1_q + sw2_q};
        we_d    = !skip_d;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      sw1_q   <= 8'd0;
      sw2_q   <= 8'd0;
      sum_q   <= 8'd0;
      rc_q    <= 16'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw1_q   <= sw1_d;
      sw2_q   <= sw2_d;
      sum_q   <= sum_d;
      rc_q    <= rc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
    end
  end

  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign we        = we_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign round_cnt = rc_q;

endmodule

// File: tb/tb_io_poll_master.sv
// Directed bench for io_poll_master.
//   u_a: READ_LAT=1, POLL_PERIOD=4. Its responder is combinational on addr.
//   u_b: READ_LAT=3, POLL_PERIOD=2. Its responder returns the switch value
//        only after addr has been stable for three cycles, and junk before
//        that.
module tb_io_poll_master;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn_a, enable_a, we_a, busy_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic [7:0]  sum_a;
  logic [15:0] rc_a;
  logic        resetn_b, enable_b, we_b, busy_b;
  logic [31:0] addr_b, wdata_b, rdata_b;
  logic [7:0]  sum_b;
  logic [15:0] rc_b;
  logic [7:0]  sw1_a, sw2_a, sw1_b, sw2_b;
  logic [31:0] ab_d1, ab_d2;

  int tests = 0;
  int fails = 0;
  int we_cnt_a = 0;
  int base;

  io_poll_master #(.POLL_PERIOD(4), .READ_LAT(1)) u_a (
    .clock(clock), .resetn(resetn_a), .enable(enable_a), .addr(addr_a),
    .wdata(wdata_a), .we(we_a), .rdata(rdata_a), .busy(busy_a),
    .sum(sum_a), .round_cnt(rc_a));

  io_poll_master #(.POLL_PERIOD(2), .READ_LAT(3)) u_b (
    .clock(clock), .resetn(resetn_b), .enable(enable_b), .addr(addr_b),
    .wdata(wdata_b), .we(we_b), .rdata(rdata_b), .busy(busy_b),
    .sum(sum_b), .round_cnt(rc_b));

  // Upper bits are junk so that the test notices any masking error.
  always_comb begin
    if (addr_a == 32'h80)      rdata_a = {24'hABCDEF, sw1_a};
    else if (addr_a == 32'h84) rdata_a = {24'hABCDEF, sw2_a};
    else                       rdata_a = 32'hDEADBEEF;
  end

  always @(posedge clock) begin
    ab_d1 <= addr_b;
    ab_d2 <= ab_d1;
  end

  always_comb begin
    rdata_b = 32'h000000EE;
    if (addr_b == ab_d1 && addr_b == ab_d2) begin
      if (addr_b == 32'h80)      rdata_b = {24'h0, sw1_b};
      else if (addr_b == 32'h84) rdata_b = {24'h0, sw2_b};
    end
  end

  always @(negedge clock) if (we_a) we_cnt_a <= we_cnt_a + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge clock); #1; end
  endtask

  task automatic wait_addr_a(input logic [31:0] a, input int lim, input string tag);
    int k = 0;
    while (addr_a !== a && k < lim) begin step(1); k++; end
    chk(tag, addr_a, a);
  endtask

  task automatic wait_rc_a(input logic [15:0] v, input int lim, input string tag);
    int k = 0;
    while (rc_a !== v && k < lim) begin step(1); k++; end
    chk(tag, {16'd0, rc_a}, {16'd0, v});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn_a = 1'b0; enable_a = 1'b1; sw1_a = 8'd3; sw2_a = 8'd5;
    resetn_b = 1'b0; enable_b = 1'b1; sw1_b = 8'hF0; sw2_b = 8'h20;
    step(3);
    chk("rst_addr", addr_a, 32'h0);
    chk("rst_we", {31'd0, we_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_rc", {16'd0, rc_a}, 32'd0);
    chk("rst_sum", {24'd0, sum_a}, 32'd0);
    chk("rst_wdata", wdata_a, 32'h0);

    // Basic round: 3 and 5
    resetn_a = 1'b1;
    step(1); chk("r1_rd1_addr", addr_a, 32'h80); chk("r1_busy", {31'd0, busy_a}, 32'd1);
    chk("r1_rd1_we", {31'd0, we_a}, 32'd0);
    step(1); chk("r1_rd2_addr", addr_a, 32'h84);
    step(1); chk("r1_w1_addr", addr_a, 32'h88); chk("r1_w1_data", wdata_a, 32'd3);
    chk("r1_w1_we", {31'd0, we_a}, 32'd1);
    step(1); chk("r1_w2_addr", addr_a, 32'h90); chk("r1_w2_data", wdata_a, 32'd5);
    chk("r1_w2_we", {31'd0, we_a}, 32'd1);
    step(1); chk("r1_w3_addr", addr_a, 32'h98); chk("r1_w3_data", wdata_a, 32'd8);
    chk("r1_w3_we", {31'd0, we_a}, 32'd1);
    step(1); chk("r1_wait_we", {31'd0, we_a}, 32'd0); chk("r1_sum", {24'd0, sum_a}, 32'd8);
    chk("r1_rc", {16'd0, rc_a}, 32'd1); chk("r1_pulses", we_cnt_a, 32'd3);
    step(3); chk("r1_wait_addr", addr_a, 32'h0); chk("r1_wait_busy", {31'd0, busy_a}, 32'd1);
    step(1); chk("r2_rd1_addr", addr_a, 32'h80);

    // Round 2: overflow, and enable dropped during WR_L2
    sw1_a = 8'hF0; sw2_a = 8'h20;
    step(1); chk("r2_rd2_addr", addr_a, 32'h84);
    step(1); chk("r2_w1_data", wdata_a, 32'hF0);
    step(1); chk("r2_w2_data", wdata_a, 32'h20); enable_a = 1'b0;
    step(1); chk("r2_w3_addr", addr_a, 32'h98); chk("r2_w3_data", wdata_a, 32'h10);
    chk("r2_w3_we", {31'd0, we_a}, 32'd1);
    step(1); chk("r2_sum", {24'd0, sum_a}, 32'h10); chk("r2_rc", {16'd0, rc_a}, 32'd2);
    step(3); chk("r2_wait_busy", {31'd0, busy_a}, 32'd1);
    step(1); chk("idle_busy", {31'd0, busy_a}, 32'd0); chk("idle_addr", addr_a, 32'h0);
    base = we_cnt_a;
    step(10); chk("idle_no_we", we_cnt_a - base, 32'd0); chk("idle_still", {31'd0, busy_a}, 32'd0);

    // Async reset during WR_L2
    sw1_a = 8'd3; sw2_a = 8'd5; enable_a = 1'b1;
    wait_addr_a(32'h90, 12, "ar_reach_wr2");
    chk("ar_we_before", {31'd0, we_a}, 32'd1);
    resetn_a = 1'b0; #1;
    chk("ar_we", {31'd0, we_a}, 32'd0);
    chk("ar_addr", addr_a, 32'h0);
    chk("ar_busy", {31'd0, busy_a}, 32'd0);
    chk("ar_rc", {16'd0, rc_a}, 32'd0);
    step(2); resetn_a = 1'b1;
    step(1); chk("ar_restart", addr_a, 32'h80);

    // Repeated identical rounds, then sw2 changes
    base = we_cnt_a;
    wait_rc_a(16'd1, 20, "rep_rc1");
    chk("rep_p1", we_cnt_a - base, 32'd3);
    wait_rc_a(16'd2, 20, "rep_rc2");
`ifdef CHANGE_ONLY_WR_EN
    chk("rep_p2", we_cnt_a - base, 32'd3);
`else
    chk("rep_p2", we_cnt_a - base, 32'd6);
`endif
    chk("rep_sum2", {24'd0, sum_a}, 32'd8);
    sw2_a = 8'd6;
    wait_rc_a(16'd3, 20, "rep_rc3");
`ifdef CHANGE_ONLY_WR_EN
    chk("rep_p3", we_cnt_a - base, 32'd6);
`else
    chk("rep_p3", we_cnt_a - base, 32'd9);
`endif
    chk("rep_sum3", {24'd0, sum_a}, 32'd9);

    // READ_LAT=3 instance: each read is held three cycles, captured on the third
    resetn_b = 1'b1;
    step(1); chk("b_rd1_c1", addr_b, 32'h80);
    step(1); chk("b_rd1_c2", addr_b, 32'h80);
    step(1); chk("b_rd1_c3", addr_b, 32'h80);
    step(1); chk("b_rd2_c1", addr_b, 32'h84);
    step(2); chk("b_rd2_c3", addr_b, 32'h84); chk("b_rd_we", {31'd0, we_b}, 32'd0);
    step(1); chk("b_w1_data", wdata_b, 32'hF0); chk("b_w1_we", {31'd0, we_b}, 32'd1);
    step(1); chk("b_w2_data", wdata_b, 32'h20);
    step(1); chk("b_w3_addr", addr_b, 32'h98); chk("b_w3_data", wdata_b, 32'h10);
    step(1); chk("b_sum", {24'd0, sum_b}, 32'h10); chk("b_rc", {16'd0, rc_b}, 32'd1);
    step(2); chk("b_next_rd", addr_b, 32'h80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/io_poll_master.md
Name: io_poll_master

Overview:
- Bus initiator for the data-memory/MMIO responder.
- Drives the same addr / write-data / write-enable bus and consumes its read data.
- Polls the two switch registers, then writes their values and their sum to the three LCD registers.
- Replaces software polling loops in test and bring-up builds; sits where the CPU's memory port would connect.

Parameters:
- POLL_PERIOD, 50000: idle cycles in WAIT between poll rounds; minimum 1.
- READ_LAT, 1: cycles each read address is held before read data is captured; minimum 1.
- SW1_ADDR, 32'h80: low switch register address.
- SW2_ADDR, 32'h84: high switch register address.
- LCD1_ADDR, 32'h88 / LCD2_ADDR, 32'h90 / LCD3_ADDR, 32'h98: LCD register addresses.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  level; run poll rounds while high.
- addr  out  32  bus address.
- wdata  out  32  bus write data.
- we  out  1  bus write enable; one-cycle pulse per write.
- rdata  in  32  bus read data; valid READ_LAT cycles after addr is stable.
- busy  out  1  high in any state other than IDLE.
- sum  out  8  last computed sum, (sw1 + sw2) & 8'hFF.
- round_cnt  out  16  completed poll rounds; wraps from 16'hFFFF to 0.

Behaviour:
- Reset (async, resetn low): state=IDLE; addr=0, wdata=0, we=0, busy=0, sum=0, round_cnt=0; captured sw1/sw2=0; latency/period counters=0.
- Reset asserted mid-round: outputs clear immediately, with no clock required. Any write pulse in flight is truncated. No resume after reset release.
- States: IDLE, RD_SW1, RD_SW2, WR_L1, WR_L2, WR_L3, WAIT.
- IDLE: addr=0, we=0. Moves to RD_SW1 on the first clock edge that samples enable=1.
- RD_SW1: addr=SW1_ADDR, we=0, held READ_LAT cycles. On the last edge, sw1 <= rdata[7:0]; go to RD_SW2.
- RD_SW2: same as RD_SW1 with SW2_ADDR; capture sw2.
- WR_L1: one cycle; addr=LCD1_ADDR, wdata={24'b0,sw1}, we=1.
- WR_L2: one cycle; addr=LCD2_ADDR, wdata={24'b0,sw2}, we=1.
- WR_L3: one cycle; addr=LCD3_ADDR, wdata={24'b0,(sw1+sw2)&8'hFF}, we=1.
- Exit of WR_L3: sum updated; round_cnt increments.
- Sum arithmetic: 9-bit sum truncated to 8 bits; carry discarded.
- WAIT: addr=0, we=0 for exactly POLL_PERIOD cycles. Then go to RD_SW1 if enable=1, else IDLE.
- enable low mid-round: the current round completes all three writes and the full WAIT, then goes to IDLE. A round is never aborted by enable.
- enable re-asserted during WAIT: no effect on timing.
- Round length: 2*READ_LAT + 3 + POLL_PERIOD cycles. With defaults: RD 2, WR 3, WAIT 50000.
- Output timing: addr, wdata and we are registered outputs, glitch-free, and change only on posedge clock.
- we is never high in any read, IDLE or WAIT state.
- rdata is ignored outside the capture edge.

Optional Feature:
CHANGE_ONLY_WR_EN:
- Defined:
  - Keep last_sw1/last_sw2 registers plus a valid flag; all clear on reset.
  - If valid=1 and both captured values equal last_sw1/last_sw2, the WR_L1–WR_L3 cycles still elapse, but we stays 0 and sum is unchanged.
  - round_cnt still increments.
  - Otherwise write normally, then update last_* and set valid=1.
  - The first round after reset always writes.
- Not defined: every round performs all three writes.

Test Plan:
- Reset values: resetn low with enable=1 -> addr=0, we=0, busy=0, round_cnt=0. Release -> RD_SW1 begins on the next edge.
- Basic round (READ_LAT=1, POLL_PERIOD=4): responder returns 3 at 0x80 and 5 at 0x84 -> exactly three we pulses, 0x88<-3, 0x90<-5, 0x98<-8, on consecutive cycles. sum=8, round_cnt=1. Next RD_SW1 starts 4 cycles after the last write.
- Overflow: rdata 8'hF0 and 8'h20 -> 0x98<-8'h10, sum=8'h10. With READ_LAT=3, each read address is held 3 cycles and is captured only on the third.
- Enable drop: enable falls during WR_L2 -> WR_L3 still writes, the full WAIT elapses, then IDLE with busy=0. No further bus activity while enable=0.
- Async reset mid-write: resetn low during WR_L2 -> we drops immediately without a clock edge. After release with enable=1, the round restarts at RD_SW1.
- CHANGE_ONLY_WR_EN: two rounds with identical switch values -> round 1 has 3 we pulses, round 2 has 0, round_cnt=2. Change sw2 in round 3 -> 3 pulses.
